systolic_feed_ctrl: RTL
=======================

# systolic_feed_ctrl

Sequencer for the 4x4 systolic array datapath. On a `start` pulse it performs one complete C = A x B tile operation:
- clears the PE accumulators;
- issues diagonally skewed reads to the banked A and B operand memories;
- qualifies the returned data into the array edge lanes;
- waits for the array to drain, then signals `done`.

It sits between the host or command logic and the array-edge operand feed.

## Interface
Parameters:
- `N`, 4: array dimension; number of A lanes (rows) and B lanes (columns).
- `AW`, 2: operand memory address width; must equal clog2(N).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin one tile operation; sampled only in IDLE.
- `busy`, out, 1: high whenever state != IDLE.
- `done`, out, 1: single-cycle completion pulse.
- `pe_clr`, out, 1: accumulator clear to all PEs.
- `a_rd_en`, out, N: per-lane read enable, A bank i (row i of A).
- `a_rd_addr`, out, N*AW: per-lane A address; lane i occupies bits [i*AW +: AW].
- `b_rd_en`, out, N: per-lane read enable, B bank j (column j of B).
- `b_rd_addr`, out, N*AW: per-lane B address, packed the same way.
- `a_vld`, out, N: lane i A data valid at the array edge.
- `b_vld`, out, N: lane j B data valid at the array edge.

## Operation
- Operand memories are synchronous-read with 1-cycle latency.
  - A bank i word k = A[i][k].
  - B bank j word k = B[k][j].
- FSM states:
  - **IDLE**: `start` = 1 -> CLEAR. Otherwise hold.
  - **CLEAR**: 1 cycle, `pe_clr` = 1 -> FEED, with step counter t = 0.
  - **FEED**: 2N-1 cycles, t = 0..2N-2. Then -> DRAIN, with counter = 0.
    - Lane i: `a_rd_en[i]` = (t >= i) && (t-i < N); `a_rd_addr` lane i = t-i when enabled, else 0.
    - Lane j of B uses the identical rule.
  - **DRAIN**: N cycles (1 memory latency + N-1 PE hops). Then -> DONE.
  - **DONE**: 1 cycle, `done` = 1 -> IDLE.
- `a_vld` / `b_vld` are the rd_en vectors registered by one cycle, so they align with the returned memory data. They are 0 in the cycle after any non-FEED cycle.
- `start` outside IDLE is ignored; it is not queued.
- `start` held high continuously gives back-to-back operations with exactly one IDLE cycle between them.
- Counter widths:
  - t needs clog2(2N-1) bits: 3 bits for N = 4.
  - The drain counter needs clog2(N) bits.
  - The subtraction t-i is evaluated at counter width + 1, so negative values are detected by the sign bit and never wrap into a valid address.

## Timing
- Cycle 0 is the first cycle after the edge that samples `start`.
  - CLEAR: cycle 0.
  - FEED: cycles 1..2N-1.
  - DRAIN: cycles 2N..3N-1.
  - DONE: cycle 3N.
- For N = 4:
  - `pe_clr` is high in cycle 0.
  - Reads occur in cycles 1..7.
  - `a_vld`/`b_vld` are active in cycles 2..8.
  - `done` is high in cycle 12.
  - `busy` is high in cycles 0..12.
- Lane 0 read window is cycles 1..4; lane 3 read window is cycles 4..7.
- All outputs are registered.
- Reset values: `busy`, `done`, `pe_clr`, all rd_en, all addresses, all vld = 0; state = IDLE; counters = 0.
- Reset asserted mid-operation: all outputs are 0 immediately (asynchronous reset); after deassertion the block is in IDLE and no `done` is issued for the aborted operation.

## Structure
- Shared package holds:
  - the state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - default N and AW;
  - FEED_LEN = 2N-1 and DRAIN_LEN = N.
- One sub-module, `skew_lane_gen`, instantiated 2N times (N for A, N for B). Per lane it:
  - takes t, the lane index and the FEED flag;
  - outputs rd_en and addr;
  - registers rd_en into vld.
- FSM and counters live in the top module.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-FEED (cycle 4) -> all outputs 0 in the same cycle; after release, `busy` = 0 and no `done` appears within 20 cycles.
- **Single op, N = 4:** `start` pulse ->
  - `pe_clr` in cycle 0;
  - `a_rd_addr` lane 2 = 0,1,2,3 in cycles 3..6;
  - `a_vld[2]` high in cycles 4..7;
  - `done` in cycle 12 only.
- **Skew check:** in cycle 4 (t = 3), `a_rd_en` = 4'b1111 with lane addresses {0,1,2,3} for lanes {3,2,1,0}. In cycle 7 (t = 6), `a_rd_en` = 4'b1000 with lane 3 address = 3. The B lanes are identical.
- **Ignored start:** pulse `start` in cycles 3 and 10 -> exactly one `done`, in cycle 12, and no second operation.
- **Back-to-back:** hold `start` high -> successive `done` pulses 14 cycles apart, one IDLE cycle between them.
- **Address bounds:** over a full operation, every enabled address is < N, and every disabled lane drives address 0.

Source files
------------

// File: rtl/systolic_feed_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feed_ctrl_pkg : shared types and sizing helpers for the feed ctrl |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package systolic_feed_ctrl_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_AW    = 2;
    localparam int FEED_LEN  = 2 * DEF_N - 1;
    localparam int DRAIN_LEN = DEF_N;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int feed_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_len(input int n);
        return n;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feed_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feed_ctrl_if : command handshake and skewed operand-feed bundle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface systolic_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int AW = 2
);
    logic            start;
    logic            busy;
    logic            done;
    logic            pe_clr;
    logic [N-1:0]    a_rd_en;
    logic [N*AW-1:0] a_rd_addr;
    logic [N-1:0]    b_rd_en;
    logic [N*AW-1:0] b_rd_addr;
    logic [N-1:0]    a_vld;
    logic [N-1:0]    b_vld;

    // master = the sequencer, slave = host plus array-edge consumers
    modport master (
        input  start,
        output busy, done, pe_clr,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_vld, b_vld
    );

    modport slave (
        output start,
        input  busy, done, pe_clr,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, a_vld, b_vld
    );
endinterface

`default_nettype wire

// File: rtl/systolic_feed_ctrl_skew_lane_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skew_lane_gen : one diagonally skewed read lane plus its data-valid stage  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module skew_lane_gen #(
    parameter int N    = 4,
    parameter int AW   = 2,
    parameter int TW   = 3,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] t_i,
    input  logic          feed_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          vld_o
);
    localparam logic [TW:0] C_LANE = (TW+1)'(LANE);
    localparam logic [TW:0] C_N    = (TW+1)'(N);

    logic [TW:0]   diff;
    logic          en_d;
    logic [AW-1:0] addr_d;
    logic          rd_en_q;
    logic [AW-1:0] addr_q;
    logic          vld_q;

    // One extra bit so t < LANE shows up as a set sign bit instead of wrapping.
    assign diff   = {1'b0, t_i} - C_LANE;
    assign en_d   = feed_i && !diff[TW] && (diff < C_N);
    assign addr_d = en_d ? diff[AW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            rd_en_q <= en_d;
            addr_q  <= addr_d;
            vld_q   <= rd_en_q;
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = addr_q;
    assign vld_o     = vld_q;

endmodule

`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_feed_ctrl : tile sequencer (clear, skewed feed, drain, done)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int AW = DEF_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    systolic_feed_ctrl_if.master feed_if
);
    localparam int TW = cnt_w(feed_len(N));
    localparam int DW = cnt_w(drain_len(N));

    localparam logic [TW-1:0] C_T_LAST = TW'(feed_len(N) - 1);
    localparam logic [DW-1:0] C_D_LAST = DW'(drain_len(N) - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
    localparam logic [2:0] S_FEED  = ST_FEED;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            busy_q, done_q, pe_clr_q;
    logic            feed_d;

    logic [N-1:0]    a_en, b_en, a_vld, b_vld;
    logic [N*AW-1:0] a_addr, b_addr;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (feed_if.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == C_T_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == C_D_LAST) state_d = S_DONE;
                else                     drain_d = drain_q + DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so every one of them comes from a flop.
    assign feed_d = (state_d == S_FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            drain_q  <= drain_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            pe_clr_q <= (state_d == S_CLEAR);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane_gen #(.N(N), .AW(AW), .TW(TW), .LANE(i)) u_a_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .t_i       (t_d),
            .feed_i    (feed_d),
            .rd_en_o   (a_en[i]),
            .rd_addr_o (a_addr[i*AW +: AW]),
            .vld_o     (a_vld[i])
        );

        skew_lane_gen #(.N(N), .AW(AW), .TW(TW), .LANE(i)) u_b_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .t_i       (t_d),
            .feed_i    (feed_d),
            .rd_en_o   (b_en[i]),
            .rd_addr_o (b_addr[i*AW +: AW]),
            .vld_o     (b_vld[i])
        );
    end

    assign feed_if.busy      = busy_q;
    assign feed_if.done      = done_q;
    assign feed_if.pe_clr    = pe_clr_q;
    assign feed_if.a_rd_en   = a_en;
    assign feed_if.a_rd_addr = a_addr;
    assign feed_if.b_rd_en   = b_en;
    assign feed_if.b_rd_addr = b_addr;
    assign feed_if.a_vld     = a_vld;
    assign feed_if.b_vld     = b_vld;

endmodule

`default_nettype wire
